// File: rtl/mem_access_unit.sv
// Byte/half/word load-store sequencer in front of a synchronous single-port RAM.
// Optional MEM_ACCESS_LWLR_EN adds the unaligned-merge loads LWL (op 8) and LWR (op 9).
module mem_access_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata
);

  localparam logic [3:0] OpLb  = 4'd0;
  localparam logic [3:0] OpLbu = 4'd1;
  localparam logic [3:0] OpLh  = 4'd2;
  localparam logic [3:0] OpLhu = 4'd3;
  localparam logic [3:0] OpLw  = 4'd4;
  localparam logic [3:0] OpSb  = 4'd5;
  localparam logic [3:0] OpSh  = 4'd6;
  localparam logic [3:0] OpSw  = 4'd7;
  localparam logic [3:0] OpLwl = 4'd8;
  localparam logic [3:0] OpLwr = 4'd9;

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  state_e      state_q;
  logic [3:0]  op_q;
  logic [1:0]  k_q;
  logic        req_err;
  logic        is_store;
  logic [3:0]  st_be;
  logic [31:0] st_wd;
  logic [31:0] rd_shift;
  logic [31:0] load_result;

  // Gated by reset_n so ready is low while reset is held, even though the state is IDLE.
  assign req_ready = (state_q == StIdle) && reset_n;
  assign is_store  = (req_op == OpSb) || (req_op == OpSh) || (req_op == OpSw);

  always_comb begin
    req_err = 1'b1;
    case (req_op)
      OpLb, OpLbu, OpSb: req_err = 1'b0;
      OpLh, OpLhu, OpSh: req_err = req_addr[0];
      OpLw, OpSw:        req_err = |req_addr[1:0];
`ifdef MEM_ACCESS_LWLR_EN
      OpLwl, OpLwr:      req_err = 1'b0;
`endif
      default:           req_err = 1'b1;
    endcase
  end

  always_comb begin
    st_be = 4'b1111;
    st_wd = req_wdata;
    case (req_op)
      OpSb: begin
        st_be = 4'b0001 << req_addr[1:0];
        st_wd = {4{req_wdata[7:0]}};
      end
      OpSh: begin
        st_be = 4'b0011 << req_addr[1:0];
        st_wd = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_shift = mem_readdata >> {k_q, 3'b000};

`ifdef MEM_ACCESS_LWLR_EN
  logic [31:0] rt_q;
  logic [4:0]  lwl_sh;
  logic [5:0]  lwl_msh;
  assign lwl_sh  = {2'd3 - k_q, 3'b000};
  assign lwl_msh = {{1'b0, k_q} + 3'd1, 3'b000};
`else
  logic unused_rt;
  assign unused_rt = ^req_rt;
`endif

  always_comb begin
    load_result = mem_readdata;
    case (op_q)
      OpLb:  load_result = {{24{rd_shift[7]}}, rd_shift[7:0]};
      OpLbu: load_result = {24'h0, rd_shift[7:0]};
      OpLh:  load_result = k_q[1] ? {{16{mem_readdata[31]}}, mem_readdata[31:16]}
                                  : {{16{mem_readdata[15]}}, mem_readdata[15:0]};
      OpLhu: load_result = k_q[1] ? {16'h0, mem_readdata[31:16]} : {16'h0, mem_readdata[15:0]};
`ifdef MEM_ACCESS_LWLR_EN
      OpLwl: load_result = (mem_readdata << lwl_sh) | (rt_q & (32'hFFFF_FFFF >> lwl_msh));
      OpLwr: load_result = rd_shift | (rt_q & ~(32'hFFFF_FFFF >> {k_q, 3'b000}));
`endif
      default: load_result = mem_readdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      op_q           <= 4'h0;
      k_q            <= 2'b00;
      resp_valid     <= 1'b0;
      resp_data      <= 32'h0;
      resp_err       <= 1'b0;
      mem_address    <= 32'h0;
      mem_byteenable <= 4'h0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= 32'h0;
`ifdef MEM_ACCESS_LWLR_EN
      rt_q           <= 32'h0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q <= req_op;
            k_q  <= req_addr[1:0];
`ifdef MEM_ACCESS_LWLR_EN
            rt_q <= req_rt;
`endif
            if (req_err) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= 32'h0;
            end else begin
              state_q        <= StIssue;
              mem_address    <= {req_addr[31:2], 2'b00};
              mem_read       <= !is_store;
              mem_write      <= is_store;
              mem_byteenable <= is_store ? st_be : 4'b1111;
              mem_writedata  <= is_store ? st_wd : 32'h0;
            end
          end
        end
        StIssue: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (mem_write) begin
            state_q        <= StResp;
            mem_byteenable <= 4'h0;
            resp_valid     <= 1'b1;
            resp_err       <= 1'b0;
            resp_data      <= 32'h0;
          end else begin
            // Byte enables stay all-ones so the RAM keeps presenting the full word.
            state_q <= StCapture;
          end
        end
        StCapture: begin
          state_q        <= StResp;
          mem_byteenable <= 4'h0;
          resp_valid     <= 1'b1;
          resp_err       <= 1'b0;
          resp_data      <= load_result;
        end
        default: begin
          state_q    <= StIdle;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a word-array reference model and a
// synchronous-read RAM. Define MEM_ACCESS_LWLR_EN to also exercise LWL/LWR.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_rt = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'h0;

`ifdef MEM_ACCESS_LWLR_EN
  localparam bit LwlrEn = 1'b1;
`else
  localparam bit LwlrEn = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] ram     [16];
  logic [31:0] ref_mem [16];
  logic [31:0] last_data;
  int          last_lat;
  int          resp_in_reset;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_rt        (req_rt),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .mem_address   (mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata)
  );

  // Synchronous RAM: one-cycle read latency, byte-enabled write.
  always @(posedge clk) begin
    if (mem_write) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byteenable[b]) ram[mem_address[5:2]][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
    end
    if (mem_read) mem_readdata <= ram[mem_address[5:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rt);
    int size, k, exp_lat, lat, n_rd, n_wr;
    bit is_ld, is_st, err;
    logic [31:0] w, b, exp_data, got_addr, got_wd;
    logic [3:0]  got_be, exp_be;
    k     = int'(addr[1:0]);
    size  = (op == 0 || op == 1 || op == 5) ? 1 : (op == 2 || op == 3 || op == 6) ? 2 : 4;
    is_st = (op >= 5 && op <= 7);
    is_ld = (op <= 4) || (LwlrEn && (op == 8 || op == 9));
    err   = !(is_st || is_ld) || (op <= 7 && (k % size) != 0);
    w     = ref_mem[addr[5:2]];
    exp_data = 32'h0;
    if (!err && is_ld) begin
      case (op)
        4'd0, 4'd1: begin
          b = (w >> (8 * k)) & 32'hFF;
          exp_data = (op == 0 && b >= 128) ? (b | 32'hFFFF_FF00) : b;
        end
        4'd2, 4'd3: begin
          b = (w >> (16 * (k / 2))) & 32'hFFFF;
          exp_data = (op == 2 && b >= 32768) ? (b | 32'hFFFF_0000) : b;
        end
        4'd8: exp_data = (w << (8 * (3 - k))) | (rt & (32'hFFFF_FFFF >> (8 * (k + 1))));
        4'd9: exp_data = (w >> (8 * k)) | (rt & ~(32'hFFFF_FFFF >> (8 * k)));
        default: exp_data = w;
      endcase
    end
    exp_lat = err ? 1 : (is_st ? 2 : 3);
    exp_be  = is_st ? 4'(((1 << size) - 1) << k) : 4'b1111;

    req_op = op; req_addr = addr; req_wdata = wd; req_rt = rt; req_valid = 1'b1;
    check("ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    lat = 0; n_rd = 0; n_wr = 0;
    got_addr = 32'h0; got_be = 4'h0; got_wd = 32'h0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req_valid = 1'b0;
      n_rd += int'(mem_read);
      n_wr += int'(mem_write);
      if (mem_read || mem_write) begin
        got_addr = mem_address; got_be = mem_byteenable; got_wd = mem_writedata;
      end
      if (cyc == 2 && is_ld && !err) check("be_capture", 32'(mem_byteenable), 32'hF);
      if (resp_valid) begin
        lat = cyc;
        break;
      end
    end
    last_lat  = lat;
    last_data = resp_data;
    check("latency", lat, exp_lat);
    check("resp_err", 32'(resp_err), 32'(err));
    check("n_read", n_rd, (is_ld && !err) ? 1 : 0);
    check("n_write", n_wr, (is_st && !err) ? 1 : 0);
    check("be_resp", 32'(mem_byteenable), 32'h0);
    if (err || is_ld) check("resp_data", resp_data, exp_data);
    if (!err) begin
      check("mem_address", got_addr, {addr[31:2], 2'b00});
      check("byteenable", 32'(got_be), 32'(exp_be));
    end
    if (is_st && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (exp_be[i]) check("writedata_lane", 32'(got_wd[8*i +: 8]), 32'(wd[8*(i-k) +: 8]));
      end
      for (int i = 0; i < size; i++) w[8*(k+i) +: 8] = wd[8*i +: 8];
      ref_mem[addr[5:2]] = w;
    end
    @(negedge clk);
    check("resp_pulse", 32'(resp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
  endtask

  always @(negedge clk) if (!reset_n && resp_valid) resp_in_reset++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[4] = 32'h8899_AABB;
    ref_mem[4] = 32'h8899_AABB;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_ctl", {resp_valid, resp_err, mem_read, mem_write, mem_byteenable}, 32'h0);
    check("rst_data", resp_data, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    do_req(4'd0, 32'h11, 32'h0, 32'h0); check("lb_11", last_data, 32'hFFFF_FFAA);
    check("lb_lat", last_lat, 3);
    do_req(4'd1, 32'h11, 32'h0, 32'h0); check("lbu_11", last_data, 32'h0000_00AA);
    do_req(4'd2, 32'h12, 32'h0, 32'h0); check("lh_12", last_data, 32'hFFFF_8899);
    do_req(4'd3, 32'h12, 32'h0, 32'h0); check("lhu_12", last_data, 32'h0000_8899);
    do_req(4'd4, 32'h10, 32'h0, 32'h0); check("lw_10", last_data, 32'h8899_AABB);
`ifdef MEM_ACCESS_LWLR_EN
    do_req(4'd8, 32'h11, 32'h0, 32'h1122_3344); check("lwl_11", last_data, 32'hAABB_3344);
    do_req(4'd9, 32'h11, 32'h0, 32'h1122_3344); check("lwr_11", last_data, 32'h1188_99AA);
`else
    do_req(4'd8, 32'h11, 32'h0, 32'h1122_3344);
    do_req(4'd9, 32'h11, 32'h0, 32'h1122_3344);
`endif
    do_req(4'd5, 32'h13, 32'h1234_56CD, 32'h0); check("sb_lat", last_lat, 2);
    do_req(4'd4, 32'h10, 32'h0, 32'h0); check("sb_result", last_data, 32'hCD99_AABB);
    do_req(4'd4, 32'h22, 32'h0, 32'h0); check("lw_mis_lat", last_lat, 1);
    do_req(4'hF, 32'h20, 32'h0, 32'h0); check("illegal_lat", last_lat, 1);

    // Reset during CAPTURE of a load: aborted with no response.
    req_op = 4'd4; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    resp_in_reset = 0;
    reset_n = 1'b0;
    #1;
    check("abort_ready", 32'(req_ready), 32'd0);
    check("abort_ctl", {resp_valid, resp_err, mem_read, mem_write, mem_byteenable}, 32'h0);
    check("abort_data", resp_data, 32'h0);
    check("abort_addr", mem_address, 32'h0);
    check("abort_wdata", mem_writedata, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_no_resp", resp_in_reset, 0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    do_req(4'd4, 32'h10, 32'h0, 32'h0); check("lw_after_rst", last_data, ref_mem[4]);

    for (int n = 0; n < 300; n++) begin
      logic [3:0]  op;
      logic [31:0] addr;
      op   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      addr = {$urandom_range(0, 255), 24'h0} | 32'($urandom_range(0, 63));
      do_req(op, addr, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
